// File: rtl/cube_pkg.sv
// Shared definitions for the cube pin interface: pin field positions, frame
// geometry and the decoder state encoding.
package cube_pkg;

  localparam int PIN_W      = 15;
  localparam int LAYER_LSB  = 12;
  localparam int ROW_LSB    = 9;
  localparam int STROBE_BIT = 8;
  localparam int DATA_LSB   = 0;
  localparam int FIELD_W    = 3;
  localparam int DATA_W     = 8;
  localparam int SLOT_W     = 6;
  localparam int SLOT_COUNT = 64;
  localparam int FRAME_BITS = 512;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } dec_state_t;

  // Slot number of a {layer,row} pair; the cell index base is slot*8.
  function automatic logic [SLOT_W-1:0] pin_slot(input logic [FIELD_W-1:0] layer,
                                                 input logic [FIELD_W-1:0] row);
    return {layer, row};
  endfunction

endpackage

// File: rtl/cube_pin_sync.sv
// Synchronizer for the whole pin bus plus a rising-edge detector on the
// synchronized latch strobe. The detector stays disarmed until the
// synchronizer chain and the history flop hold post-reset pin values, so a
// strobe already high at reset release never produces a latch event.
module cube_pin_sync
  import cube_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PIN_W-1:0]    pins,
  output logic [SLOT_W-1:0]   slot,
  output logic [DATA_W-1:0]   data,
  output logic                latch_evt
);

  localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

  logic [PIN_W-1:0] stage_r [SYNC_STAGES];
  logic             strobe_prev_r;
  logic [2:0]       prime_r;
  logic [PIN_W-1:0] sync_s;

  // Shift every pin bit through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_r[i] <= {PIN_W{1'b0}};
      end
    end else begin
      stage_r[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  // Track strobe history and arm the detector once the chain has filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_prev_r <= 1'b0;
      prime_r       <= 3'd0;
    end else begin
      strobe_prev_r <= sync_s[STROBE_BIT];
      if (prime_r != PRIME_DONE) begin
        prime_r <= prime_r + 3'd1;
      end else begin
        prime_r <= prime_r;
      end
    end
  end

  // Split the synchronized bus and flag a 0->1 strobe transition.
  always_comb begin
    sync_s    = stage_r[SYNC_STAGES-1];
    slot      = pin_slot(sync_s[LAYER_LSB +: FIELD_W], sync_s[ROW_LSB +: FIELD_W]);
    data      = sync_s[DATA_LSB +: DATA_W];
    latch_evt = (prime_r == PRIME_DONE) && sync_s[STROBE_BIT] && !strobe_prev_r;
  end

endmodule

// File: rtl/cube_pin_decoder.sv
// Cube pin decoder: collects 64 latched row writes into a shadow frame and
// publishes the frame on Cells once every slot has been written. Partial
// frames are dropped after TIMEOUT idle cycles.
module cube_pin_decoder
  import cube_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [PIN_W-1:0]      Pins,
  input  logic                  ClrErr,
  output logic [FRAME_BITS-1:0] Cells,
  output logic                  FrameValid,
  output logic [15:0]           FrameCount,
  output logic                  DupErr,
  output logic                  SyncLost
);

  localparam int               IDLE_W   = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

  logic [SLOT_W-1:0]     slot_s;
  logic [DATA_W-1:0]     data_s;
  logic                  latch_evt_s;
  logic [SLOT_COUNT-1:0] slot_bit_s;
  logic                  mask_full_s;
  logic                  dup_s;
  logic                  timeout_s;

  dec_state_t            state_r;
  logic [SLOT_COUNT-1:0] mask_r;
  logic [FRAME_BITS-1:0] shadow_r;
  logic [IDLE_W-1:0]     idle_r;
  logic [FRAME_BITS-1:0] cells_r;
  logic                  frame_valid_r;
  logic [15:0]           frame_count_r;
  logic                  dup_err_r;
  logic                  sync_lost_r;

  cube_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .clk       (Clk),
    .rst_n     (Reset),
    .pins      (Pins),
    .slot      (slot_s),
    .data      (data_s),
    .latch_evt (latch_evt_s)
  );

  // Decode the current latch: target slot bit, frame completion, duplicate, timeout.
  always_comb begin
    slot_bit_s  = {{(SLOT_COUNT-1){1'b0}}, 1'b1} << slot_s;
    mask_full_s = &(mask_r | slot_bit_s);
    dup_s       = latch_evt_s && mask_r[slot_s];
    timeout_s   = !latch_evt_s && (idle_r == IDLE_MAX) && (mask_r != {SLOT_COUNT{1'b0}});
  end

  // Idle counter: restarts on every latch event, saturates at TIMEOUT.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      idle_r <= {IDLE_W{1'b0}};
    end else if (latch_evt_s) begin
      idle_r <= {IDLE_W{1'b0}};
    end else if (idle_r != IDLE_MAX) begin
      idle_r <= idle_r + {{(IDLE_W-1){1'b0}}, 1'b1};
    end else begin
      idle_r <= idle_r;
    end
  end

  // Shadow frame: every latch event writes its row byte, duplicates included.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      shadow_r <= {FRAME_BITS{1'b0}};
    end else if (latch_evt_s) begin
      shadow_r[{slot_s, 3'b000} +: DATA_W] <= data_s;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Sticky error flags; a new error in the ClrErr cycle keeps the flag set.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      dup_err_r   <= 1'b0;
      sync_lost_r <= 1'b0;
    end else begin
      dup_err_r   <= dup_s     || (dup_err_r   && !ClrErr);
      sync_lost_r <= timeout_s || (sync_lost_r && !ClrErr);
    end
  end

  // Frame FSM: mask tracking, commit of the shadow frame and frame counting.
  // The mask is cleared on the edge that fills it, so a latch in the COMMIT
  // cycle already lands in an empty mask and opens the next frame.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r       <= ST_IDLE;
      mask_r        <= {SLOT_COUNT{1'b0}};
      cells_r       <= {FRAME_BITS{1'b0}};
      frame_valid_r <= 1'b0;
      frame_count_r <= 16'd0;
    end else begin
      frame_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (latch_evt_s) begin
            mask_r  <= slot_bit_s;
            state_r <= ST_FILL;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FILL: begin
          if (latch_evt_s && mask_full_s) begin
            mask_r  <= {SLOT_COUNT{1'b0}};
            state_r <= ST_COMMIT;
          end else if (latch_evt_s) begin
            mask_r  <= mask_r | slot_bit_s;
            state_r <= ST_FILL;
          end else if (timeout_s) begin
            mask_r  <= {SLOT_COUNT{1'b0}};
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_FILL;
          end
        end
        ST_COMMIT: begin
          cells_r       <= shadow_r;
          frame_valid_r <= 1'b1;
          frame_count_r <= frame_count_r + 16'd1;
          if (latch_evt_s) begin
            mask_r  <= slot_bit_s;
            state_r <= ST_FILL;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          mask_r  <= {SLOT_COUNT{1'b0}};
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign Cells      = cells_r;
  assign FrameValid = frame_valid_r;
  assign FrameCount = frame_count_r;
  assign DupErr     = dup_err_r;
  assign SyncLost   = sync_lost_r;

endmodule

// File: tb/tb_cube_pin_decoder.sv
// Self-checking bench for cube_pin_decoder with a transaction-level frame model.
module tb_cube_pin_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 100;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [14:0]  Pins;
  logic         ClrErr;
  logic [511:0] Cells;
  logic         FrameValid;
  logic [15:0]  FrameCount;
  logic         DupErr;
  logic         SyncLost;

  cube_pin_decoder #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Pins       (Pins),
    .ClrErr     (ClrErr),
    .Cells      (Cells),
    .FrameValid (FrameValid),
    .FrameCount (FrameCount),
    .DupErr     (DupErr),
    .SyncLost   (SyncLost)
  );

  always #5 Clk = ~Clk;

  int compared   = 0;
  int mismatched = 0;
  int fv_seen    = 0;

  // Count FrameValid cycles; a pulse wider than one cycle shows up as extra counts.
  always @(negedge Clk) begin
    if (FrameValid === 1'b1) fv_seen++;
  end

  // ---------------- reference model ----------------
  logic [7:0]   m_shadow [64];
  bit           m_written [64];
  logic [511:0] m_cells;
  logic [15:0]  m_count;
  bit           m_dup;
  bit           m_lost;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_shadow[i]  = 8'h00;
      m_written[i] = 1'b0;
    end
    m_cells = '0;
    m_count = 16'd0;
    m_dup   = 1'b0;
    m_lost  = 1'b0;
  endfunction

  function automatic void model_latch(input int slot, input logic [7:0] d);
    int filled;
    if (m_written[slot]) m_dup = 1'b1;
    m_shadow[slot]  = d;
    m_written[slot] = 1'b1;
    filled = 0;
    for (int i = 0; i < 64; i++) if (m_written[i]) filled++;
    if (filled == 64) begin
      for (int k = 0; k < 64; k++) begin
        m_cells[8*k +: 8] = m_shadow[k];
        m_written[k]      = 1'b0;
      end
      m_count = m_count + 16'd1;
    end
  endfunction

  function automatic void model_timeout();
    bit any;
    any = 1'b0;
    for (int i = 0; i < 64; i++) if (m_written[i]) any = 1'b1;
    if (any) begin
      for (int i = 0; i < 64; i++) m_written[i] = 1'b0;
      m_lost = 1'b1;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_latch(input int slot, input logic [7:0] d, input int hold, input int gap);
    logic [5:0] s6;
    s6   = slot[5:0];
    Pins = {s6, 1'b1, d};
    model_latch(slot, d);
    repeat (hold) @(negedge Clk);
    Pins[8] = 1'b0;
    repeat (gap) @(negedge Clk);
  endtask

  task automatic send_frame_random(input int skip, input int max_gap);
    int order [64];
    int tmp;
    int j;
    for (int i = 0; i < 64; i++) order[i] = i;
    for (int i = 63; i > 0; i--) begin
      j        = int'($urandom_range(i, 0));
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 64; i++) begin
      if (order[i] != skip) begin
        drive_latch(order[i], 8'($urandom), 1, int'($urandom_range(max_gap, 1)));
      end
    end
  endtask

  task automatic settle();
    repeat (SYNC_STAGES + 4) @(negedge Clk);
  endtask

  task automatic pulse_reset();
    Reset = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (SYNC_STAGES + 4) @(negedge Clk);
  endtask

  task automatic clear_errors();
    ClrErr = 1'b1;
    @(negedge Clk);
    ClrErr = 1'b0;
    m_dup  = 1'b0;
    m_lost = 1'b0;
    @(negedge Clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Pins   = 15'h0100;
    ClrErr = 1'b0;
    Reset  = 1'b0;
    model_reset();
    repeat (3) @(negedge Clk);
    compared++;
    if (Cells !== 512'd0) begin
      mismatched++; $display("FAIL reset_cells: got %0h expected 0", Cells);
    end
    compared++;
    if ({FrameValid, FrameCount, DupErr, SyncLost} !== 19'd0) begin
      mismatched++;
      $display("FAIL reset_flags: got fv=%b cnt=%0d dup=%b lost=%b expected all 0",
               FrameValid, FrameCount, DupErr, SyncLost);
    end
    // Release with the strobe already high: no latch may be taken.
    Reset = 1'b1;
    repeat (8) @(negedge Clk);
    compared++;
    if (dut.mask_r !== 64'd0) begin
      mismatched++; $display("FAIL reset_release_strobe: mask got %0h expected 0", dut.mask_r);
    end
    Pins = 15'h0000;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_ordered_frame();
    int fv0;
    int cyc;
    bit found;
    logic [5:0] kk;
    fv0 = fv_seen;
    for (int s = 0; s < 63; s++) begin
      kk = s[5:0];
      drive_latch(s, {kk, 2'b01}, 1, 1);
    end
    // Last latch: measure pin-to-FrameValid latency.
    Pins = {6'd63, 1'b1, 8'hFD};
    model_latch(63, 8'hFD);
    cyc   = 0;
    found = 1'b0;
    while (!found && cyc < 20) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 1) Pins[8] = 1'b0;
      if (FrameValid === 1'b1) found = 1'b1;
    end
    compared++;
    if (cyc != SYNC_STAGES + 2) begin
      mismatched++; $display("FAIL ordered_latency: got %0d cycles expected %0d", cyc, SYNC_STAGES + 2);
    end
    settle();
    compared++;
    if (fv_seen - fv0 != 1) begin
      mismatched++; $display("FAIL ordered_fv_count: got %0d expected 1", fv_seen - fv0);
    end
    compared++;
    if (FrameCount !== 16'd1) begin
      mismatched++; $display("FAIL ordered_framecount: got %0d expected 1", FrameCount);
    end
    for (int k = 0; k < 64; k++) begin
      kk = k[5:0];
      compared++;
      if (Cells[8*k +: 8] !== {kk, 2'b01}) begin
        mismatched++;
        $display("FAIL ordered_byte_%0d: got %0h expected %0h", k, Cells[8*k +: 8], {kk, 2'b01});
      end
    end
    compared++;
    if (Cells !== m_cells) begin
      mismatched++; $display("FAIL ordered_model: got %0h expected %0h", Cells, m_cells);
    end
  endtask

  task automatic test_duplicate();
    int fv0;
    fv0 = fv_seen;
    drive_latch(5, 8'hAA, 1, 1);
    drive_latch(5, 8'h55, 1, 1);
    send_frame_random(5, 2);
    settle();
    compared++;
    if (DupErr !== 1'b1) begin
      mismatched++; $display("FAIL dup_flag: got %b expected 1", DupErr);
    end
    compared++;
    if (Cells[47:40] !== 8'h55) begin
      mismatched++; $display("FAIL dup_slot5: got %0h expected 55", Cells[47:40]);
    end
    compared++;
    if (fv_seen - fv0 != 1) begin
      mismatched++; $display("FAIL dup_fv_count: got %0d expected 1", fv_seen - fv0);
    end
    compared++;
    if (Cells !== m_cells) begin
      mismatched++; $display("FAIL dup_cells: got %0h expected %0h", Cells, m_cells);
    end
    clear_errors();
    compared++;
    if (DupErr !== 1'b0) begin
      mismatched++; $display("FAIL dup_clear: got %b expected 0", DupErr);
    end
  endtask

  task automatic test_timeout();
    int fv0;
    int start;
    logic [511:0] cells_before;
    cells_before = m_cells;
    fv0   = fv_seen;
    start = int'($urandom_range(63, 0));
    for (int i = 0; i < 10; i++) begin
      drive_latch((start + 7 * i) % 64, 8'($urandom), 1, int'($urandom_range(2, 1)));
    end
    repeat (TIMEOUT + SYNC_STAGES + 10) @(negedge Clk);
    model_timeout();
    compared++;
    if (SyncLost !== 1'b1) begin
      mismatched++; $display("FAIL timeout_synclost: got %b expected 1", SyncLost);
    end
    compared++;
    if (Cells !== cells_before) begin
      mismatched++; $display("FAIL timeout_cells_kept: got %0h expected %0h", Cells, cells_before);
    end
    compared++;
    if (fv_seen != fv0) begin
      mismatched++; $display("FAIL timeout_no_fv: got %0d expected %0d", fv_seen, fv0);
    end
    send_frame_random(-1, 2);
    settle();
    compared++;
    if (fv_seen - fv0 != 1) begin
      mismatched++; $display("FAIL timeout_next_fv: got %0d expected 1", fv_seen - fv0);
    end
    compared++;
    if (Cells !== m_cells) begin
      mismatched++; $display("FAIL timeout_next_cells: got %0h expected %0h", Cells, m_cells);
    end
    compared++;
    if ({FrameCount, DupErr, SyncLost} !== {m_count, m_dup, m_lost}) begin
      mismatched++;
      $display("FAIL timeout_next_flags: got cnt=%0d dup=%b lost=%b expected cnt=%0d dup=%b lost=%b",
               FrameCount, DupErr, SyncLost, m_count, m_dup, m_lost);
    end
    clear_errors();
    compared++;
    if (SyncLost !== 1'b0) begin
      mismatched++; $display("FAIL timeout_clear: got %b expected 0", SyncLost);
    end
  endtask

  task automatic test_held_strobe();
    int fv0;
    fv0 = fv_seen;
    drive_latch(0, 8'($urandom), 20, 1);
    settle();
    compared++;
    if (dut.mask_r !== 64'h1) begin
      mismatched++; $display("FAIL held_mask: got %0h expected 1", dut.mask_r);
    end
    compared++;
    if (DupErr !== 1'b0) begin
      mismatched++; $display("FAIL held_duperr: got %b expected 0", DupErr);
    end
    send_frame_random(0, 2);
    settle();
    compared++;
    if (fv_seen - fv0 != 1) begin
      mismatched++; $display("FAIL held_fv_count: got %0d expected 1", fv_seen - fv0);
    end
    compared++;
    if (Cells !== m_cells) begin
      mismatched++; $display("FAIL held_cells: got %0h expected %0h", Cells, m_cells);
    end
  endtask

  task automatic test_reset_midframe();
    int fv0;
    int start;
    start = int'($urandom_range(63, 0));
    for (int i = 0; i < 30; i++) begin
      drive_latch((start + 5 * i) % 64, 8'($urandom), 1, 1);
    end
    Pins  = {6'($urandom), 1'b1, 8'($urandom)};
    Reset = 1'b0;
    model_reset();
    #1;
    compared++;
    if (Cells !== 512'd0) begin
      mismatched++; $display("FAIL midreset_cells: got %0h expected 0", Cells);
    end
    compared++;
    if ({FrameValid, FrameCount, DupErr, SyncLost} !== 19'd0) begin
      mismatched++;
      $display("FAIL midreset_flags: got fv=%b cnt=%0d dup=%b lost=%b expected all 0",
               FrameValid, FrameCount, DupErr, SyncLost);
    end
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (6) @(negedge Clk);
    Pins[8] = 1'b0;
    @(negedge Clk);
    fv0 = fv_seen;
    send_frame_random(-1, 2);
    settle();
    compared++;
    if (FrameCount !== 16'd1) begin
      mismatched++; $display("FAIL midreset_framecount: got %0d expected 1", FrameCount);
    end
    compared++;
    if (fv_seen - fv0 != 1) begin
      mismatched++; $display("FAIL midreset_fv_count: got %0d expected 1", fv_seen - fv0);
    end
    compared++;
    if (Cells !== m_cells) begin
      mismatched++; $display("FAIL midreset_cells_after: got %0h expected %0h", Cells, m_cells);
    end
  endtask

  task automatic test_back_to_back();
    int fv0;
    pulse_reset();
    fv0 = fv_seen;
    // Tightest strobe spacing: the next frame opens right behind the commit.
    send_frame_random(-1, 1);
    send_frame_random(-1, 1);
    settle();
    compared++;
    if (FrameCount !== 16'd2) begin
      mismatched++; $display("FAIL b2b_framecount: got %0d expected 2", FrameCount);
    end
    compared++;
    if (fv_seen - fv0 != 2) begin
      mismatched++; $display("FAIL b2b_fv_count: got %0d expected 2", fv_seen - fv0);
    end
    compared++;
    if (SyncLost !== 1'b0) begin
      mismatched++; $display("FAIL b2b_synclost: got %b expected 0", SyncLost);
    end
    compared++;
    if (Cells !== m_cells) begin
      mismatched++; $display("FAIL b2b_cells: got %0h expected %0h", Cells, m_cells);
    end
  endtask

  // Bound the whole run so a stalled design cannot hang the bench.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_ordered_frame();
    test_duplicate();
    test_timeout();
    test_held_strobe();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
